mult_div_sequencer: RTL and testbench
=====================================

# mult_div_sequencer

Iterative MULTU/DIVU engine that borrows the shared 32-bit ALU and uses it for one ADD or SUB per cycle, over 32 cycles. It holds the HI/LO result registers, grants the ALU to itself only while an operation runs, and gives the core busy/done handshakes so control can stall and later read HI/LO.

## Interface
Parameters:
- `ITERATIONS`, 32: iteration count; equals operand width; fixed at 32 for this core.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `start`  in  1  request; sampled only in IDLE.
- `op_div`  in  1  0 = multiply, 1 = divide.
- `op_signed`  in  1  signed variant; used only under `MULT_DIV_SIGNED_EN`.
- `rs_data`  in  32  multiplicand / dividend.
- `rt_data`  in  32  multiplier / divisor.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle.
- `done`  out  1  one-cycle pulse; HI/LO are valid from this cycle on.
- `hi`  out  32  product[63:32] or remainder.
- `lo`  out  32  product[31:0] or quotient.
- `alu_req`  out  1  high in RUN only; datapath ALU input mux selects this block's operands.
- `alu_op`  out  4  ADD = 4'b0011, SUB = 4'b0100; 4'b0000 when not in RUN.
- `alu_a`, `alu_b`  out  32  ALU operands; 0 when not in RUN.
- `alu_result`  in  32  ALU result; combinational, same cycle.

## Operation
- States: IDLE → RUN (32 cycles) → [FIXUP] → DONE → IDLE. 5-bit iteration counter, cleared on entry to RUN.
- Start accept: on the edge where IDLE && `start`, latch operands and clear the accumulator.
- Divide by zero (`op_div` && `rt_data`==0): go IDLE → DONE directly. Result: HI = `rs_data`, LO = 32'hFFFFFFFF.
- MULTU iteration (ACC = HI, Q = LO holding the multiplier):
  - `alu_a` = ACC, `alu_b` = multiplicand, `alu_op` = ADD.
  - If Q[0]: sum = `alu_result`, carry = (sum < ACC) unsigned; else sum = ACC, carry = 0.
  - {ACC, Q} ← {carry, sum, Q} >> 1.
- DIVU iteration (R = HI, Q = LO holding the dividend):
  - msb = R[31]; R' = {R[30:0], Q[31]}; Q' = Q << 1.
  - `alu_a` = R', `alu_b` = divisor, `alu_op` = SUB.
  - If msb or R' >= divisor: R ← `alu_result`, Q ← Q' | 1; else R ← R', Q ← Q'.
- Carry and compare logic is local. The ALU Zero output is unused.
- HI/LO keep their value until the next accepted start. Reading HI/LO while busy returns intermediate state.

## Timing
- Reset values: `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0, `alu_req` = 0, `alu_op` = 0, `alu_a` = 0, `alu_b` = 0. State = IDLE, counter = 0.
- Start accepted at edge 0 → RUN in cycles 1–32 → DONE in cycle 33, with `done` = 1 and `busy` = 1 → IDLE in cycle 34.
- Divide by zero: `done` in cycle 1.
- `start` asserted while `busy`: ignored, not queued.
- `start` asserted in the DONE cycle: ignored. The earliest accept is in cycle 34.
- Reset asserted mid-RUN: abort at once. All outputs return to reset values and `alu_req` drops asynchronously.
- `alu_req` rises at the first RUN cycle and falls after the last one. The ALU mux switches the same cycle, with no turnaround cycle.

## Configuration
`MULT_DIV_SIGNED_EN`:
- Defined:
  - When `op_signed` = 1, negative operands are converted to magnitude at start using local two's-complement logic.
  - A FIXUP state (one cycle, between RUN and DONE) negates the results:
    - MULT: negate the 64-bit product if operand signs differ.
    - DIV: negate the quotient if operand signs differ; the remainder takes the dividend's sign.
  - With FIXUP, `done` arrives in cycle 34.
  - Signed divide by zero behaves like unsigned, using the raw `rs_data`.
- Undefined: `op_signed` is ignored, there is no FIXUP state, and every operation is unsigned.

## Structure
- Shared package `mips_pkg`:
  - ALU op encodings (AND/OR/NOR/ADD/SUB/LUI/JAL, 4-bit).
  - Sequencer state enum `md_state_t`.
  - `ITERATIONS` default.
- Optional sub-module `md_sign_fix`: combinational magnitude/negate helper, instantiated only under `MULT_DIV_SIGNED_EN`.
- Everything else lives in one module.

## Test plan
- MULTU 32'hFFFFFFFF × 32'hFFFFFFFF → HI = 32'hFFFFFFFE, LO = 32'h00000001. `done` at cycle 33; `alu_req` high exactly cycles 1–32 with `alu_op` = 4'b0011.
- DIVU 100 / 7 → LO = 14, HI = 2. DIVU 32'h80000000 / 3 → LO = 32'h2AAAAAAA, HI = 2.
- DIVU 32'h12345678 / 0 → `done` at cycle 1, HI = 32'h12345678, LO = 32'hFFFFFFFF, `alu_req` never high.
- `start` pulsed at cycles 5 and 33 of a running MULTU 3 × 4 → single `done`, HI = 0, LO = 12. A new start at cycle 34 is accepted.
- Reset dropped at cycle 10 of a DIVU → all outputs 0 immediately. A following MULTU 6 × 7 → LO = 42.
- With `MULT_DIV_SIGNED_EN`:
  - MULT −3 × 5 → HI = 32'hFFFFFFFF, LO = 32'hFFFFFFF1, `done` at cycle 34.
  - DIV −7 / 2 → LO = 32'hFFFFFFFD, HI = 32'hFFFFFFFF.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the core: ALU op encodings, multiply/divide
// sequencer state type and the default iteration count.
package mips_pkg;

    localparam int unsigned ITERATIONS_DEFAULT = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_NOR = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_LUI = 4'b0101;
    localparam logic [3:0] ALU_JAL = 4'b0110;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_RUN,
        MD_FIXUP,
        MD_DONE
    } md_state_t;

endpackage

// File: rtl/md_sign_fix.sv
// Combinational two's-complement helper: passes value through or negates it.
// Used only by the signed build of mult_div_sequencer.
module md_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? ('0 - value) : value;

endmodule

// File: rtl/mult_div_sequencer.sv
// Iterative MULTU/DIVU engine driving the shared ALU one ADD/SUB per cycle.
// Define MULT_DIV_SIGNED_EN to add signed operation with a FIXUP state.
module mult_div_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned ITERATIONS = ITERATIONS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op_div,
    input  logic        op_signed,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        alu_req,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result
);

    localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);

    md_state_t   state;
    md_state_t   state_next;
    logic [4:0]  count;
    logic [31:0] opnd;
    logic        div_r;
    logic        div_zero;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] rem_shift;
    logic [31:0] step_hi;
    logic [31:0] step_lo;
    logic [31:0] mul_sum;
    logic        mul_carry;

    assign div_zero  = op_div && (rt_data == '0);
    assign rem_shift = {hi[30:0], lo[31]};

`ifdef MULT_DIV_SIGNED_EN
    logic        sign_a;
    logic        sign_b;
    logic        sign_a_r;
    logic        sign_b_r;
    logic [63:0] fix_prod;
    logic [31:0] fix_rem;
    logic [31:0] fix_quo;

    assign sign_a = op_signed & rs_data[31];
    assign sign_b = op_signed & rt_data[31];

    md_sign_fix #(.WIDTH(32)) u_mag_a (.value(rs_data), .negate(sign_a), .result(mag_a));
    md_sign_fix #(.WIDTH(32)) u_mag_b (.value(rt_data), .negate(sign_b), .result(mag_b));
    md_sign_fix #(.WIDTH(64)) u_fix_prod (.value({hi, lo}), .negate(sign_a_r ^ sign_b_r), .result(fix_prod));
    md_sign_fix #(.WIDTH(32)) u_fix_rem (.value(hi), .negate(sign_a_r), .result(fix_rem));
    md_sign_fix #(.WIDTH(32)) u_fix_quo (.value(lo), .negate(sign_a_r ^ sign_b_r), .result(fix_quo));
`else
    logic unused_signed;
    assign unused_signed = op_signed;
    assign mag_a = rs_data;
    assign mag_b = rt_data;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    state_next = div_zero ? MD_DONE : MD_RUN;
                end
            end
            MD_RUN: begin
                if (count == LAST_ITER) begin
`ifdef MULT_DIV_SIGNED_EN
                    state_next = MD_FIXUP;
`else
                    state_next = MD_DONE;
`endif
                end
            end
            MD_FIXUP: state_next = MD_DONE;
            MD_DONE:  state_next = MD_IDLE;
            default:  state_next = MD_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != MD_IDLE);
        done    = (state == MD_DONE);
        alu_req = 1'b0;
        alu_op  = '0;
        alu_a   = '0;
        alu_b   = '0;
        if (state == MD_RUN) begin
            alu_req = 1'b1;
            alu_b   = opnd;
            if (div_r) begin
                alu_op = ALU_SUB;
                alu_a  = rem_shift;
            end else begin
                alu_op = ALU_ADD;
                alu_a  = hi;
            end
        end
    end

    // One shift-add (multiply) or restoring-subtract (divide) step; hi[31] set
    // before the shift means the 33-bit partial remainder already exceeds the divisor.
    always_comb begin
        step_hi   = hi;
        step_lo   = lo;
        mul_sum   = hi;
        mul_carry = 1'b0;
        if (div_r) begin
            if (hi[31] || (rem_shift >= opnd)) begin
                step_hi = alu_result;
                step_lo = {lo[30:0], 1'b1};
            end else begin
                step_hi = rem_shift;
                step_lo = {lo[30:0], 1'b0};
            end
        end else begin
            if (lo[0]) begin
                mul_sum   = alu_result;
                mul_carry = (alu_result < hi);
            end
            step_hi = {mul_carry, mul_sum[31:1]};
            step_lo = {mul_sum[0], lo[31:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi    <= '0;
            lo    <= '0;
            opnd  <= '0;
            div_r <= 1'b0;
            count <= '0;
`ifdef MULT_DIV_SIGNED_EN
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
`endif
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        div_r <= op_div;
                        count <= '0;
`ifdef MULT_DIV_SIGNED_EN
                        sign_a_r <= sign_a & ~div_zero;
                        sign_b_r <= sign_b & ~div_zero;
`endif
                        if (div_zero) begin
                            hi <= rs_data;
                            lo <= '1;
                        end else if (op_div) begin
                            hi   <= '0;
                            lo   <= mag_a;
                            opnd <= mag_b;
                        end else begin
                            hi   <= '0;
                            lo   <= mag_b;
                            opnd <= mag_a;
                        end
                    end
                end
                MD_RUN: begin
                    hi    <= step_hi;
                    lo    <= step_lo;
                    count <= count + 5'd1;
                end
`ifdef MULT_DIV_SIGNED_EN
                MD_FIXUP: begin
                    if (div_r) begin
                        hi <= fix_rem;
                        lo <= fix_quo;
                    end else begin
                        hi <= fix_prod[63:32];
                        lo <= fix_prod[31:0];
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed-vector bench for mult_div_sequencer with a behavioural ALU.
// Expected values are hand-computed; honours MULT_DIV_SIGNED_EN.
module tb_mult_div_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op_div;
    logic        op_signed;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        alu_req;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MULT_DIV_SIGNED_EN
    localparam int DONE_CYC = 34;
`else
    localparam int DONE_CYC = 33;
`endif

    mult_div_sequencer #(.ITERATIONS(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op_div     (op_div),
        .op_signed  (op_signed),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .alu_req    (alu_req),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result)
    );

    always_comb begin
        case (alu_op)
            4'b0011: alu_result = alu_a + alu_b;
            4'b0100: alu_result = alu_a - alu_b;
            default: alu_result = '0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Cycle c is the interval after edge c-1 (edge 0 accepts start); sampled at negedge.
    task automatic run_op(input string tag, input logic div, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int exp_done, input int exp_req, input bit pulses);
        int ndone;
        int done_cyc;
        int nreq;
        int req_first;
        int badop;
        ndone = 0; done_cyc = 0; nreq = 0; req_first = 0; badop = 0;
        @(negedge clk);
        op_div = div; op_signed = sgn; rs_data = a; rt_data = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= exp_done + 1; c++) begin
            @(negedge clk);
            if (c == 1) check({tag, " busy@1"}, 64'(busy), 64'd1);
            if (done) begin
                ndone++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (alu_req) begin
                nreq++;
                if (req_first == 0) req_first = c;
                if (alu_op !== (div ? 4'b0100 : 4'b0011)) badop++;
            end else if (alu_op !== 4'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
                badop++;
            end
            if (pulses) begin
                rs_data = 32'hDEAD0000; rt_data = 32'd9;
                start = (c == 5 || c == exp_done);
            end
        end
        check({tag, " done_cycle"}, 64'(done_cyc), 64'(exp_done));
        check({tag, " done_count"}, 64'(ndone), 64'd1);
        check({tag, " req_cycles"}, 64'(nreq), 64'(exp_req));
        check({tag, " req_first"}, 64'(req_first), (exp_req != 0) ? 64'd1 : 64'd0);
        check({tag, " alu_idle_op"}, 64'(badop), 64'd0);
        check({tag, " idle_busy_done"}, {62'd0, busy, done}, 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        int guard;
        reset = 1'b0; start = 1'b0; op_div = 1'b0; op_signed = 1'b0;
        rs_data = '0; rt_data = '0;
        #2;
        check("reset outputs", {busy, done, alu_req, alu_op, hi, lo}, 64'd0);
        check("reset alu ab", {alu_a, alu_b}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_op("multu ffff", 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001, DONE_CYC, 32, 1'b0);
        run_op("divu 100/7", 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, DONE_CYC, 32, 1'b0);
        run_op("divu 8000/3", 1'b1, 1'b0, 32'h80000000, 32'd3,
               32'd2, 32'h2AAAAAAA, DONE_CYC, 32, 1'b0);
        run_op("divu by0", 1'b1, 1'b0, 32'h12345678, 32'd0,
               32'h12345678, 32'hFFFFFFFF, 1, 0, 1'b0);

        // Start pulses during RUN and DONE must be ignored; then accept in first idle cycle.
        run_op("multu 3x4 pulses", 1'b0, 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, DONE_CYC, 32, 1'b1);
        rs_data = 32'd3; rt_data = 32'd4; op_div = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("restart accepted busy", 64'(busy), 64'd1);
        guard = 0;
        while (!done && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        check("restart done seen", 64'(done), 64'd1);
        check("restart lo", 64'(lo), 64'd12);
        @(negedge clk);

        // Asynchronous abort in cycle 10 of a divide.
        @(negedge clk);
        op_div = 1'b1; op_signed = 1'b0; rs_data = 32'd1000; rt_data = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check("pre-abort alu_req", 64'(alu_req), 64'd1);
        reset = 1'b0;
        #1;
        check("abort outputs", {busy, done, alu_req, alu_op, hi, lo}, 64'd0);
        check("abort alu ab", {alu_a, alu_b}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op("multu 6x7", 1'b0, 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, DONE_CYC, 32, 1'b0);

`ifdef MULT_DIV_SIGNED_EN
        run_op("mult -3x5", 1'b0, 1'b1, 32'hFFFFFFFD, 32'd5,
               32'hFFFFFFFF, 32'hFFFFFFF1, DONE_CYC, 32, 1'b0);
        run_op("div -7/2", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,
               32'hFFFFFFFF, 32'hFFFFFFFD, DONE_CYC, 32, 1'b0);
        run_op("div signed by0", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd0,
               32'hFFFFFFF9, 32'hFFFFFFFF, 1, 0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
